// File: rtl/gba_pll_cfg_pkg.sv
// Shared types and constants for the PLL reconfiguration master.
// Holds the register map, the per-profile write table and the FSM state encoding.
package gba_pll_cfg_pkg;

  localparam int CFG_NUM_PROFILES = 2;
  localparam int CFG_PROFILE_LEN  = 4;
  localparam int CFG_PW           = (CFG_NUM_PROFILES > 1) ? $clog2(CFG_NUM_PROFILES) : 1;
  localparam int CFG_IW           = $clog2(CFG_PROFILE_LEN) + 1;

  localparam logic [5:0] REG_MODE  = 6'd0;
  localparam logic [5:0] REG_START = 6'd2;
  localparam logic [5:0] REG_N     = 6'd3;
  localparam logic [5:0] REG_M     = 6'd4;
  localparam logic [5:0] REG_C     = 6'd5;
  localparam logic [5:0] REG_K     = 6'd7;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } cfg_write_t;

  // Counter and fractional words for each clock plan; regenerate them if the reference clock changes.
  localparam cfg_write_t CFG_TABLE [CFG_NUM_PROFILES][CFG_PROFILE_LEN] = '{
    '{'{REG_N, 32'h0001_0000}, '{REG_M, 32'h0000_0808}, '{REG_C, 32'h0000_0404}, '{REG_K, 32'h2D0E_5604}},
    '{'{REG_N, 32'h0002_0000}, '{REG_M, 32'h0000_0909}, '{REG_C, 32'h0000_0404}, '{REG_K, 32'h3A8F_5C29}}
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_WRITE,
    ST_START,
    ST_WAIT_UNLOCK,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/gba_pll_cfg_rom.sv
// Registered lookup of one profile table entry; one cycle from (profile, index) to rd_q.
// Indices past the end of a profile read as all-zero.
module gba_pll_cfg_rom
  import gba_pll_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CFG_PW-1:0] profile,
  input  logic [CFG_IW-1:0] index,
  output cfg_write_t        rd_q
);

  cfg_write_t rd_d;

  always_comb begin
    rd_d = '0;
    if (index < CFG_IW'(CFG_PROFILE_LEN)) begin
      rd_d = CFG_TABLE[profile][index[CFG_IW-2:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/gba_pll_reconfig.sv
// Avalon-MM write master that loads a PLL profile, triggers reconfiguration and supervises relock.
// Requests arriving while busy are held as a single latest-wins pending request.
module gba_pll_reconfig
  import gba_pll_cfg_pkg::*;
#(
  parameter int NUM_PROFILES = CFG_NUM_PROFILES,
  parameter int PROFILE_LEN  = CFG_PROFILE_LEN,
  parameter int UNLOCK_WAIT  = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req,
  input  logic [$clog2(NUM_PROFILES)-1:0] req_profile,
  input  logic                            pll_locked,
  input  logic                            mgmt_waitrequest,
  output logic [5:0]                      mgmt_address,
  output logic [31:0]                     mgmt_writedata,
  output logic                            mgmt_write,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [$clog2(NUM_PROFILES)-1:0] cur_profile
);

  localparam int PW = $clog2(NUM_PROFILES);
  localparam int IW = CFG_IW;

  state_e          state_q, state_d;
  logic [PW-1:0]   prof_q, prof_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            pend_vld_q, pend_vld_d;
  logic [PW-1:0]   pend_prof_q, pend_prof_d;
  logic            error_q, error_d;
  logic [PW-1:0]   cur_q, cur_d;
  logic            mgmt_wr_q, mgmt_wr_d;
  logic [5:0]      mgmt_addr_q, mgmt_addr_d;
  logic [31:0]     mgmt_data_q, mgmt_data_d;

  logic [PW-1:0]   rom_prof;
  logic [IW-1:0]   rom_idx;
  cfg_write_t      rom_q;

  logic            wr_done;
  logic            in_flight;
  logic            acc_vld;
  logic [PW-1:0]   acc_prof;

  assign wr_done   = mgmt_wr_q & ~mgmt_waitrequest;
  assign in_flight = (state_q == ST_MODE) || (state_q == ST_WRITE) || (state_q == ST_START) ||
                     (state_q == ST_WAIT_UNLOCK) || (state_q == ST_WAIT_LOCK);
  assign acc_vld   = req | pend_vld_q;
  assign acc_prof  = req ? req_profile : pend_prof_q;

  gba_pll_cfg_rom u_rom (
    .clk     (clk),
    .rst     (rst),
    .profile (rom_prof),
    .index   (rom_idx),
    .rd_q    (rom_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prof_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_prof_q <= '0;
      error_q     <= 1'b0;
      cur_q       <= '0;
      mgmt_wr_q   <= 1'b0;
      mgmt_addr_q <= '0;
      mgmt_data_q <= '0;
    end else begin
      state_q     <= state_d;
      prof_q      <= prof_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_prof_q <= pend_prof_d;
      error_q     <= error_d;
      cur_q       <= cur_d;
      mgmt_wr_q   <= mgmt_wr_d;
      mgmt_addr_q <= mgmt_addr_d;
      mgmt_data_q <= mgmt_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (acc_vld) state_d = ((acc_prof != cur_q) || error_q) ? ST_MODE : ST_DONE;
      ST_MODE:        if (wr_done) state_d = ST_WRITE;
      ST_WRITE:       if (wr_done && (idx_q == IW'(PROFILE_LEN - 1))) state_d = ST_START;
      ST_START:       if (wr_done) state_d = ST_WAIT_UNLOCK;
      ST_WAIT_UNLOCK: if (!pll_locked || (cnt_q >= 16'(UNLOCK_WAIT))) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (pll_locked) state_d = ST_DONE;
        else if (cnt_q >= 16'(LOCK_TIMEOUT)) state_d = ST_ERROR;
      end
      default:        state_d = ST_IDLE;
    endcase
  end

  // The ROM always holds the entry that the next completed write will present, so a
  // completing cycle looks one further ahead and a stalled cycle keeps the current lookahead.
  always_comb begin
    prof_d      = prof_q;
    idx_d       = idx_q;
    pend_vld_d  = pend_vld_q;
    pend_prof_d = pend_prof_q;
    error_d     = error_q;
    cur_d       = cur_q;
    mgmt_wr_d   = mgmt_wr_q;
    mgmt_addr_d = mgmt_addr_q;
    mgmt_data_d = mgmt_data_q;
    cnt_d       = (state_d != state_q) ? 16'd0 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
    rom_prof    = prof_q;
    rom_idx     = '0;

    if (in_flight && req) begin
      pend_vld_d  = 1'b1;
      pend_prof_d = req_profile;
    end

    case (state_q)
      ST_IDLE: begin
        rom_prof = acc_prof;
        if (acc_vld) begin
          prof_d     = acc_prof;
          pend_vld_d = 1'b0;
          if (state_d == ST_MODE) begin
            error_d     = 1'b0;
            mgmt_wr_d   = 1'b1;
            mgmt_addr_d = REG_MODE;
            mgmt_data_d = '0;
          end
        end
      end
      ST_MODE: begin
        rom_idx = IW'(wr_done);
        if (wr_done) begin
          idx_d       = '0;
          mgmt_addr_d = rom_q.addr;
          mgmt_data_d = rom_q.data;
        end
      end
      ST_WRITE: begin
        rom_idx = idx_q + IW'(1) + IW'(wr_done);
        if (wr_done) begin
          idx_d = idx_q + IW'(1);
          if (state_d == ST_START) begin
            mgmt_addr_d = REG_START;
            mgmt_data_d = '0;
          end else begin
            mgmt_addr_d = rom_q.addr;
            mgmt_data_d = rom_q.data;
          end
        end
      end
      ST_START: begin
        if (wr_done) begin
          mgmt_wr_d   = 1'b0;
          mgmt_addr_d = '0;
          mgmt_data_d = '0;
        end
      end
      default: ;
    endcase

    if (state_d == ST_DONE) cur_d = prof_d;
    if (state_d == ST_ERROR) error_d = 1'b1;
  end

  assign mgmt_write     = mgmt_wr_q;
  assign mgmt_address   = mgmt_addr_q;
  assign mgmt_writedata = mgmt_data_q;
  assign busy           = in_flight;
  assign done           = (state_q == ST_DONE);
  assign error          = error_q;
  assign cur_profile    = cur_q;

endmodule

// File: tb/tb_gba_pll_reconfig.sv
// Directed bench for gba_pll_reconfig: write sequences, waitrequest stalls, lock timeouts,
// same-profile shortcut, pending requests and mid-sequence reset.
module tb_gba_pll_reconfig;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [0:0]  req_profile;
  logic        pll_locked;
  logic        mgmt_waitrequest;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        busy;
  logic        done;
  logic        error;
  logic [0:0]  cur_profile;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [37:0] exp_p0 [6];
  logic [37:0] exp_p1 [6];

  always #5 clk = ~clk;

  gba_pll_reconfig dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_profile      (req_profile),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_write       (mgmt_write),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .cur_profile      (cur_profile)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    int bad;

    exp_p0[0] = {6'd0, 32'h0000_0000};
    exp_p0[1] = {6'd3, 32'h0001_0000};
    exp_p0[2] = {6'd4, 32'h0000_0808};
    exp_p0[3] = {6'd5, 32'h0000_0404};
    exp_p0[4] = {6'd7, 32'h2D0E_5604};
    exp_p0[5] = {6'd2, 32'h0000_0000};
    exp_p1[0] = {6'd0, 32'h0000_0000};
    exp_p1[1] = {6'd3, 32'h0002_0000};
    exp_p1[2] = {6'd4, 32'h0000_0909};
    exp_p1[3] = {6'd5, 32'h0000_0404};
    exp_p1[4] = {6'd7, 32'h3A8F_5C29};
    exp_p1[5] = {6'd2, 32'h0000_0000};

    rst = 1'b1;
    req = 1'b0;
    req_profile = 1'b0;
    pll_locked = 1'b1;
    mgmt_waitrequest = 1'b0;
    repeat (3) tick();
    chk("reset_mgmt", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'd0);
    chk("reset_status", 64'({busy, done, error, cur_profile}), 64'd0);
    rst = 1'b0;
    tick();

    // Same profile while idle: immediate done, no bus traffic.
    req = 1'b1; req_profile = 1'b0;
    tick();
    req = 1'b0;
    chk("same_prof_done", 64'({done, busy, mgmt_write}), 64'b100);
    tick();
    chk("same_prof_after", 64'({done, busy, mgmt_write, cur_profile}), 64'd0);

    // Profile 1, zero waitrequest, lock drops then returns 500 cycles later.
    req = 1'b1; req_profile = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("p1_seq", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'({1'b1, exp_p1[i]}));
      tick();
    end
    chk("p1_seq_end", 64'({mgmt_write, busy}), 64'b01);
    bad = 0;
    for (int i = 0; i < 509; i++) begin
      if (i == 9) pll_locked = 1'b0;
      tick();
      if (busy !== 1'b1) bad++;
    end
    chk("p1_busy_span", 64'(bad), 64'd0);
    pll_locked = 1'b1;
    chk("p1_done_before_lock", 64'(done), 64'd0);
    tick();
    chk("p1_done", 64'({done, cur_profile}), 64'b11);
    tick();
    chk("p1_idle", 64'({done, busy, cur_profile}), 64'b001);

    // Profile 0 with waitrequest held 3 cycles on every write.
    req = 1'b1; req_profile = 1'b0;
    tick();
    req = 1'b0;
    for (int w = 0; w < 6; w++) begin
      for (int c = 0; c < 4; c++) begin
        mgmt_waitrequest = (c < 3);
        chk("p0_hold", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'({1'b1, exp_p0[w]}));
        tick();
      end
    end
    chk("p0_seq_end", 64'(mgmt_write), 64'd0);
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    tick();
    chk("p0_done", 64'({done, cur_profile}), 64'b10);
    tick();

    // Lock never returns: timeout to error, profile unchanged.
    req = 1'b1; req_profile = 1'b1; pll_locked = 1'b0;
    tick();
    req = 1'b0;
    k = 0;
    while (error !== 1'b1 && k < 70000) begin
      tick();
      k++;
    end
    chk("lock_timeout_window", 64'(k >= 65541 && k <= 65545), 64'd1);
    chk("lock_timeout_state", 64'({error, busy, done, cur_profile}), 64'b1000);
    tick();

    // Retry clears error; lock never drops so the unlock wait expires.
    req = 1'b1; req_profile = 1'b1; pll_locked = 1'b1;
    tick();
    req = 1'b0;
    chk("retry_accept", 64'({error, mgmt_write, busy}), 64'b011);
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    chk("unlock_timeout_window", 64'(k >= 262 && k <= 264), 64'd1);
    chk("unlock_timeout_done", 64'({done, error, cur_profile}), 64'b101);
    tick();

    // Profile 0 accepted, then 0 and 1 requested while busy; latest pending wins.
    req = 1'b1; req_profile = 1'b0; pll_locked = 1'b0;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1; req_profile = 1'b0;
    tick();
    req = 1'b1; req_profile = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    pll_locked = 1'b1;
    tick();
    chk("pend_first_done", 64'({done, cur_profile}), 64'b10);
    tick();
    chk("pend_idle_gap", 64'({done, busy, mgmt_write}), 64'd0);
    tick();
    chk("pend_second_w0", 64'({busy, mgmt_write, mgmt_address, mgmt_writedata}), 64'({2'b11, exp_p1[0]}));
    tick();
    chk("pend_second_w1", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'({1'b1, exp_p1[1]}));
    tick();
    chk("pend_second_w2", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'({1'b1, exp_p1[2]}));
    mgmt_waitrequest = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_mid_mgmt", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'd0);
    chk("rst_mid_status", 64'({busy, done, error, cur_profile}), 64'd0);
    rst = 1'b0;
    mgmt_waitrequest = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mgmt_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("rst_pending_cleared", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gba_pll_reconfig.md
# gba_pll_reconfig

Avalon-MM write master that reprograms the system PLL between fixed frequency profiles. It drives the `altera_pll_reconfig` management port, issues the start command, then supervises the PLL `locked` output until relock. It reports completion or timeout to the core-level clock-control logic. It runs on the free-running 50 MHz reference clock, which is unaffected by the reconfiguration.

## Interface
Parameters:
- `NUM_PROFILES`, 2: number of selectable profiles. Profile 0 is nominal 100.663296/50.331648 MHz; profile 1 is the 60 Hz-synced variant.
- `PROFILE_LEN`, 4: register writes per profile, excluding the mode and start writes.
- `UNLOCK_WAIT`, 255: cycles to wait for `locked` to drop after start.
- `LOCK_TIMEOUT`, 65535: cycles to wait for `locked` to rise.

Ports:
- `clk` in 1: 50 MHz reference clock, the only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: single-cycle request strobe.
- `req_profile` in $clog2(NUM_PROFILES): profile to apply; sampled while `req`=1.
- `pll_locked` in 1: PLL lock output, already synchronised to `clk`.
- `mgmt_waitrequest` in 1: Avalon waitrequest from the reconfig block.
- `mgmt_address` out 6: Avalon address.
- `mgmt_writedata` out 32: Avalon write data.
- `mgmt_write` out 1: Avalon write.
- `busy` out 1: high from request acceptance until DONE or ERROR.
- `done` out 1: one-cycle pulse on successful relock.
- `error` out 1: sticky; set on lock timeout, cleared by the next accepted request.
- `cur_profile` out $clog2(NUM_PROFILES): last successfully applied profile.

## Operation
- FSM states: IDLE, MODE, WRITE, START, WAIT_UNLOCK, WAIT_LOCK, DONE, ERROR.
- IDLE, `req`=1, `req_profile`≠`cur_profile` or `error`=1: latch the profile, clear `error`, set `busy`, go to MODE.
- IDLE, `req`=1, `req_profile`==`cur_profile` and `error`=0: no bus traffic; go to DONE directly.
- MODE: write address 0, data 0 (waitrequest mode). Then go to WRITE with index 0.
- WRITE: present `cfg_rom[profile][index]`. Advance the index on each completed write. After index `PROFILE_LEN`-1 completes, go to START.
- START: write address 2, data 0. Then go to WAIT_UNLOCK and clear the counter.
- WAIT_UNLOCK: when `pll_locked`=0, go to WAIT_LOCK and clear the counter. If the counter reaches `UNLOCK_WAIT`, go to WAIT_LOCK anyway (a small fractional change may not drop lock).
- WAIT_LOCK: when `pll_locked`=1, go to DONE. If the counter reaches `LOCK_TIMEOUT`, go to ERROR.
- DONE: pulse `done`, load `cur_profile` from the latched profile, drop `busy`, return to IDLE.
- ERROR: set `error`, drop `busy`, return to IDLE. `cur_profile` is unchanged.
- Avalon handshake: a write completes on the edge where `mgmt_write`=1 and `mgmt_waitrequest`=0. Address and data hold stable while waitrequest is high. `mgmt_write` never drops before completion.
- `req` while `busy`: the latest request is stored as pending, overwriting any earlier pending one. It is accepted in the IDLE cycle after DONE or ERROR. Other requests are ignored.
- The counter is 16 bits and saturates; it never wraps.

## Timing
- Reset values: `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0, `busy`=0, `done`=0, `error`=0, `cur_profile`=0, pending cleared, FSM in IDLE.
- `rst` mid-transaction deasserts `mgmt_write` on the next edge; no write completes after the reset edge.
- Latency from `req` at edge N:
  - `mgmt_write`=1 from N+1.
  - With zero waitrequest, MODE, the `PROFILE_LEN` writes and START take `PROFILE_LEN`+2 cycles in total.
  - `done` is asserted one cycle after `pll_locked`=1 is seen in WAIT_LOCK.
  - Same-profile request: `done` at N+1, `busy` stays 0.
- `mgmt_*` outputs are registered; no combinational path from `mgmt_waitrequest` to `mgmt_write`.

## Structure
- Package `gba_pll_cfg_pkg` holds:
  - typedef `cfg_write_t` {addr[5:0], data[31:0]};
  - constants `REG_MODE`=0, `REG_START`=2, `REG_N`=3, `REG_M`=4, `REG_C`=5, `REG_K`=7;
  - the `cfg_write_t` profile table `[NUM_PROFILES][PROFILE_LEN]`;
  - the state enum.
- One sub-module, `gba_pll_cfg_rom`: registered table lookup (profile, index) -> `cfg_write_t`. Its one-cycle latency is hidden by prefetching index 0 during MODE.

## Test plan
- Reset, then `req` profile 1 with waitrequest tied 0: exact sequence is (0,0), the 4 profile-1 table entries, then (2,0), one per cycle. Model drops lock 10 cycles later and raises it 500 cycles later. Expect `done` one cycle after lock, `cur_profile`=1, `busy` high for the whole span.
- Waitrequest high for 3 cycles on every write: each write holds address and data stable for 4 cycles, and completes exactly once.
- Lock never returns: `error`=1 after 65535 cycles in WAIT_LOCK, `cur_profile`=0, `busy`=0. A following `req` profile 1 clears `error` and reprograms.
- Lock never drops and stays high: WAIT_UNLOCK times out after 255 cycles, then `done` fires one cycle later.
- `req` profile 0 while idle at profile 0: `done` at N+1, no `mgmt_write`.
- `req` profile 0 then profile 1 while busy, then `rst` asserted during the second sequence's third write: outputs return to reset values on the next edge, no further writes, pending request cleared.
